// File: rtl/tnn_column.sv
// Temporal-neural-network column: M ramp-no-leak neurons over N spike-time inputs, 1-WTA, optional STDP.
// Latency: out_valid T+1 cycles after start (T+2 with training); start and host writes are ignored while busy.
module tnn_column #(
  parameter int N         = 8,
  parameter int M         = 4,
  parameter int WBITS     = 3,
  parameter int WMAX      = 7,
  parameter int WINIT     = 0,
  parameter int T         = 8,
  parameter int THRESH    = 8,
  parameter int SEARCH_EN = 1,
  localparam int TBITS    = (T > 1) ? $clog2(T) : 1,
  localparam int NB       = (N > 1) ? $clog2(N) : 1,
  localparam int MB       = (M > 1) ? $clog2(M) : 1,
  localparam int FW       = TBITS + 1
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              start,
  input  logic              training,
  input  logic [N*FW-1:0]   in_times,
  input  logic              wt_wr_en,
  input  logic [MB-1:0]     wt_neuron,
  input  logic [NB-1:0]     wt_input,
  input  logic [WBITS-1:0]  wt_wr_data,
  output logic [WBITS-1:0]  wt_rd_data,
  output logic              busy,
  output logic              out_valid,
  output logic              out_spike,
  output logic [TBITS-1:0]  out_time,
  output logic [MB-1:0]     out_winner
);

  localparam int PBITS = WBITS + NB + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_LEARN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [TBITS-1:0] T_LAST   = TBITS'(T - 1);
  localparam logic [N*FW-1:0]  NO_SPIKE = {N{{1'b1, {TBITS{1'b0}}}}};

  logic [1:0]        state_q, state_d;
  logic [TBITS-1:0]  t_q, t_d;
  logic [N*FW-1:0]   in_q;
  logic              train_q;
  logic [WBITS-1:0]  w_q     [M][N];
  logic [WBITS-1:0]  w_learn [M][N];
  logic [M-1:0]      fired_q;
  logic [TBITS-1:0]  ftime_q [M];

  logic              out_valid_q, out_spike_q;
  logic [TBITS-1:0]  out_time_q;
  logic [MB-1:0]     out_winner_q;

  logic [N-1:0]      spk;
  logic [TBITS-1:0]  st [N];
  logic [PBITS-1:0]  pot [M];
  logic [M-1:0]      hit;
  logic              win_found;
  logic [MB-1:0]     win_idx;
  logic [TBITS-1:0]  win_time;
  logic [WBITS-1:0]  wr_clamp;
  logic              accept;

  assign accept     = (state_q == S_IDLE) && start;
  assign busy       = (state_q != S_IDLE);
  assign wr_clamp   = (wt_wr_data > WBITS'(WMAX)) ? WBITS'(WMAX) : wt_wr_data;
  assign wt_rd_data = w_q[wt_neuron][wt_input];

  assign out_valid  = out_valid_q;
  assign out_spike  = out_spike_q;
  assign out_time   = out_time_q;
  assign out_winner = out_winner_q;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      spk[i] = ~in_q[i*FW + TBITS];
      st[i]  = in_q[i*FW +: TBITS];
    end
  end

  // Potential is rebuilt every step from the latched spike times, so no accumulator state is needed.
  always_comb begin
    for (int j = 0; j < M; j++) begin
      pot[j] = '0;
      for (int i = 0; i < N; i++) begin
        if (spk[i] && (st[i] <= t_q))
          pot[j] = pot[j] + PBITS'(w_q[j][i]);
      end
      hit[j] = (pot[j] >= PBITS'(THRESH));
    end
  end

  // Strict less-than while scanning upward keeps the lowest index on a tie.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '1;
    win_time  = '0;
    for (int j = 0; j < M; j++) begin
      if (fired_q[j] && (!win_found || (ftime_q[j] < win_time))) begin
        win_found = 1'b1;
        win_idx   = MB'(j);
        win_time  = ftime_q[j];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < M; j++) begin
      for (int i = 0; i < N; i++) begin
        logic inc, dec;
        inc = 1'b0;
        dec = 1'b0;
        if (win_found && (win_idx == MB'(j))) begin
          inc = spk[i] && (st[i] <= win_time);
          dec = !inc;
        end else if (!fired_q[j] && (SEARCH_EN != 0)) begin
          inc = spk[i];
        end
        w_learn[j][i] = w_q[j][i];
        if (inc && (w_q[j][i] < WBITS'(WMAX)))
          w_learn[j][i] = w_q[j][i] + 1'b1;
        else if (dec && (w_q[j][i] != '0))
          w_learn[j][i] = w_q[j][i] - 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          t_d     = '0;
        end
      end
      S_RUN: begin
        if (t_q == T_LAST) begin
          state_d = train_q ? S_LEARN : S_DONE;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      S_LEARN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      in_q    <= NO_SPIKE;
      train_q <= 1'b0;
      fired_q <= '0;
      for (int j = 0; j < M; j++) ftime_q[j] <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      if (accept) begin
        in_q    <= in_times;
        train_q <= training;
        fired_q <= '0;
        for (int j = 0; j < M; j++) ftime_q[j] <= '0;
      end else if (state_q == S_RUN) begin
        for (int j = 0; j < M; j++) begin
          if (hit[j] && !fired_q[j]) begin
            fired_q[j] <= 1'b1;
            ftime_q[j] <= t_q;
          end
        end
      end
    end
  end

  // A write in the start cycle lands before the first RUN step reads the array.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int j = 0; j < M; j++)
        for (int i = 0; i < N; i++)
          w_q[j][i] <= WBITS'(WINIT);
    end else if (state_q == S_LEARN) begin
      w_q <= w_learn;
    end else if (wt_wr_en && (state_q == S_IDLE)) begin
      w_q[wt_neuron][wt_input] <= wr_clamp;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      out_valid_q  <= 1'b0;
      out_spike_q  <= 1'b0;
      out_time_q   <= '0;
      out_winner_q <= '1;
    end else begin
      out_valid_q <= (state_q == S_DONE);
      if (state_q == S_DONE) begin
        out_spike_q  <= win_found;
        out_time_q   <= win_time;
        out_winner_q <= win_idx;
      end
    end
  end

endmodule

// File: tb/tb_tnn_column.sv
// Randomised scoreboard bench for tnn_column against a spike-time reference model.
module tb_tnn_column;

  localparam int N = 8, M = 4, WBITS = 3, WMAX = 7, T = 8, THRESH = 8, FW = 4;
  localparam int SEARCH_EN = 1;
  localparam int NONE_WIN = (1 << $clog2(M)) - 1;

  logic             clk, rst_l, start, training, wt_wr_en;
  logic [N*FW-1:0]  in_times;
  logic [1:0]       wt_neuron;
  logic [2:0]       wt_input, wt_wr_data, wt_rd_data;
  logic             busy, out_valid, out_spike;
  logic [2:0]       out_time;
  logic [1:0]       out_winner;

  logic             start5, training5, wt_wr_en5;
  logic [N*FW-1:0]  in_times5;
  logic [1:0]       wt_neuron5;
  logic [2:0]       wt_input5, wt_wr_data5, wt_rd_data5;
  logic             busy5, out_valid5, out_spike5;
  logic [2:0]       out_time5;
  logic [1:0]       out_winner5;

  tnn_column u_dut (
    .clk(clk), .rst_l(rst_l), .start(start), .training(training), .in_times(in_times),
    .wt_wr_en(wt_wr_en), .wt_neuron(wt_neuron), .wt_input(wt_input), .wt_wr_data(wt_wr_data),
    .wt_rd_data(wt_rd_data), .busy(busy), .out_valid(out_valid), .out_spike(out_spike),
    .out_time(out_time), .out_winner(out_winner)
  );

  tnn_column #(.WMAX(5)) u_dut5 (
    .clk(clk), .rst_l(rst_l), .start(start5), .training(training5), .in_times(in_times5),
    .wt_wr_en(wt_wr_en5), .wt_neuron(wt_neuron5), .wt_input(wt_input5), .wt_wr_data(wt_wr_data5),
    .wt_rd_data(wt_rd_data5), .busy(busy5), .out_valid(out_valid5), .out_spike(out_spike5),
    .out_time(out_time5), .out_winner(out_winner5)
  );

  typedef struct {
    int spike;
    int tim;
    int winner;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   mw[M][N];
  int   tw[M][N];
  int   ev_t[N];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_l && out_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_valid: out_valid at cycle %0d with no result pending", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("valid_cycle", cyc, e.cyc);
        check("out_spike", int'(out_spike), e.spike);
        check("out_time", int'(out_time), e.tim);
        check("out_winner", int'(out_winner), e.winner);
      end
    end
  end

  function automatic int sat(input int v);
    return (v < 0) ? 0 : (v > WMAX) ? WMAX : v;
  endfunction

  function automatic logic [N*FW-1:0] pack_times();
    logic [N*FW-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++)
      p[i*FW +: FW] = (ev_t[i] < 0) ? 4'b1000 : {1'b0, 3'(ev_t[i])};
    return p;
  endfunction

  // Fire time of each neuron is the first step its summed arrived weight reaches THRESH.
  task automatic model_run(input int train, output exp_t e);
    int f[M];
    int win, sum;
    for (int j = 0; j < M; j++) begin
      f[j] = -1;
      for (int t = 0; t < T; t++) begin
        if (f[j] < 0) begin
          sum = 0;
          for (int i = 0; i < N; i++)
            if (ev_t[i] >= 0 && ev_t[i] <= t) sum += mw[j][i];
          if (sum >= THRESH) f[j] = t;
        end
      end
    end
    win = -1;
    for (int j = 0; j < M; j++)
      if (f[j] >= 0 && (win < 0 || f[j] < f[win])) win = j;
    e.spike  = (win >= 0) ? 1 : 0;
    e.tim    = (win >= 0) ? f[win] : 0;
    e.winner = (win >= 0) ? win : NONE_WIN;
    e.cyc    = 0;
    if (train != 0) begin
      for (int j = 0; j < M; j++)
        for (int i = 0; i < N; i++) begin
          if (j == win)
            mw[j][i] = sat(mw[j][i] + ((ev_t[i] >= 0 && ev_t[i] <= f[win]) ? 1 : -1));
          else if (f[j] < 0 && SEARCH_EN != 0 && ev_t[i] >= 0)
            mw[j][i] = sat(mw[j][i] + 1);
        end
    end
  endtask

  task automatic host_write(input int j, input int i, input int v);
    @(negedge clk);
    wt_wr_en = 1'b1; wt_neuron = 2'(j); wt_input = 3'(i); wt_wr_data = 3'(v);
    @(posedge clk);
    #1;
    wt_wr_en = 1'b0;
    mw[j][i] = (v > WMAX) ? WMAX : v;
  endtask

  task automatic load_tw();
    for (int j = 0; j < M; j++)
      for (int i = 0; i < N; i++)
        host_write(j, i, tw[j][i]);
  endtask

  task automatic clear_tw();
    for (int j = 0; j < M; j++)
      for (int i = 0; i < N; i++)
        tw[j][i] = 0;
  endtask

  task automatic clear_ev();
    for (int i = 0; i < N; i++) ev_t[i] = -1;
  endtask

  // wj >= 0 adds a host write in the same cycle as start.
  task automatic issue_start(input int train, input int wj, input int wi, input int wv);
    exp_t e;
    int c;
    @(negedge clk);
    in_times = pack_times();
    training = (train != 0);
    start    = 1'b1;
    if (wj >= 0) begin
      wt_wr_en = 1'b1; wt_neuron = 2'(wj); wt_input = 3'(wi); wt_wr_data = 3'(wv);
    end
    @(posedge clk);
    #1;
    c = cyc;
    start    = 1'b0;
    wt_wr_en = 1'b0;
    if (wj >= 0) mw[wj][wi] = (wv > WMAX) ? WMAX : wv;
    model_run(train, e);
    e.cyc = c + T + 1 + ((train != 0) ? 1 : 0);
    sbq.push_back(e);
    in_times = $urandom;
    training = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout: %0d result(s) never arrived", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  task automatic read_w(input int j, input int i, input int exp);
    wt_neuron = 2'(j); wt_input = 3'(i);
    #1;
    check($sformatf("rd_w%0d_%0d", j, i), int'(wt_rd_data), exp);
  endtask

  task automatic readback();
    for (int j = 0; j < M; j++)
      for (int i = 0; i < N; i++)
        read_w(j, i, mw[j][i]);
  endtask

  task automatic setup_s1();
    clear_tw(); tw[2][0] = 7; tw[2][1] = 7; load_tw();
    clear_ev(); ev_t[0] = 3; ev_t[1] = 3;
  endtask

  initial begin
    rst_l = 1'b0; start = 1'b0; training = 1'b0; wt_wr_en = 1'b0; in_times = '1;
    wt_neuron = '0; wt_input = '0; wt_wr_data = '0;
    start5 = 1'b0; training5 = 1'b0; wt_wr_en5 = 1'b0; in_times5 = '1;
    wt_neuron5 = '0; wt_input5 = '0; wt_wr_data5 = '0;
    for (int j = 0; j < M; j++) for (int i = 0; i < N; i++) mw[j][i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_spike", int'(out_spike), 0);
    check("rst_time", int'(out_time), 0);
    check("rst_winner", int'(out_winner), NONE_WIN);
    readback();

    setup_s1();
    issue_start(0, -1, 0, 0);
    wait_done();
    check("s1_winner", int'(out_winner), 2);
    check("s1_time", int'(out_time), 3);
    readback();

    clear_tw(); tw[1][0] = 7; tw[1][1] = 7; tw[3][0] = 7; tw[3][1] = 7; load_tw();
    issue_start(0, -1, 0, 0);
    wait_done();
    check("tie_winner", int'(out_winner), 1);

    clear_ev();
    issue_start(0, -1, 0, 0);
    wait_done();
    check("none_winner", int'(out_winner), NONE_WIN);
    check("none_spike", int'(out_spike), 0);

    setup_s1(); ev_t[5] = 6;
    issue_start(1, -1, 0, 0);
    wait_done();
    readback();
    read_w(2, 0, 7); read_w(2, 5, 0); read_w(1, 5, 1); read_w(3, 2, 0);

    setup_s1();
    issue_start(0, -1, 0, 0);
    @(negedge clk);
    start = 1'b1; wt_wr_en = 1'b1; wt_neuron = 2'd0; wt_input = 3'd0; wt_wr_data = 3'd5;
    @(posedge clk);
    #1;
    start = 1'b0; wt_wr_en = 1'b0;
    wait_done();
    repeat (T + 4) @(negedge clk);
    read_w(0, 0, 0);
    readback();

    clear_tw(); tw[0][0] = 7; load_tw();
    clear_ev(); ev_t[0] = 2; ev_t[1] = 2;
    issue_start(0, 0, 1, 7);
    wait_done();
    check("samecyc_winner", int'(out_winner), 0);
    check("samecyc_time", int'(out_time), 2);

    @(negedge clk);
    wt_wr_en5 = 1'b1; wt_neuron5 = 2'd1; wt_input5 = 3'd4; wt_wr_data5 = 3'd7;
    @(negedge clk);
    wt_wr_en5 = 1'b0;
    #1;
    check("clamp_wmax5", int'(wt_rd_data5), 5);
    check("dut5_idle", int'(busy5) + int'(out_valid5) + int'(out_spike5) + int'(out_time5), 0);
    check("dut5_winner", int'(out_winner5), NONE_WIN);

    setup_s1();
    issue_start(0, -1, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    rst_l = 1'b0;
    sbq.delete();
    for (int j = 0; j < M; j++) for (int i = 0; i < N; i++) mw[j][i] = 0;
    #2;
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(out_valid), 0);
    check("abort_winner", int'(out_winner), NONE_WIN);
    @(negedge clk);
    rst_l = 1'b1;
    readback();
    repeat (T + 4) @(negedge clk);
    setup_s1();
    issue_start(0, -1, 0, 0);
    wait_done();
    check("post_abort_winner", int'(out_winner), 2);

    for (int k = 0; k < 24; k++) begin
      if (k == 0 || $urandom_range(0, 2) == 0) begin
        for (int j = 0; j < M; j++)
          for (int i = 0; i < N; i++)
            tw[j][i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 7));
        load_tw();
      end
      for (int i = 0; i < N; i++)
        ev_t[i] = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, T - 1));
      issue_start(int'($urandom_range(0, 1)), -1, 0, 0);
      wait_done();
      readback();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
